spi_master: RTL and testbench

Byte-stream SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
- Pulls transmit bytes from a FIFO-style source (get/empty) and shifts each out on spi_mosi while sampling spi_miso.
- Pushes each received byte to a FIFO-style sink (put/full).
- Sits between on-chip byte queues and an external SPI slave. Keeps chip select asserted across back-to-back bytes.

---
 rtl/spi_master_pkg.sv | 14 +
 rtl/spi_clkdiv.sv | 44 ++++
 rtl/spi_master.sv | 134 +++++++++++++
 tb/tb_spi_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: the byte width and the FSM state encoding.
package spi_master_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period tick generator for the SPI clock.
// While enabled it counts DIV system clocks per half period and flags which
// SPI clock edge (rising or falling) the end of the current half produces.
// Disabling it returns the phase to "low" so every byte starts cleanly.
module spi_clkdiv
  import spi_master_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_enable,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_phase;
  logic             w_tick;

  assign w_tick = i_enable && (r_count == LAST);
  assign o_rise = w_tick && !r_phase;
  assign o_fall = w_tick && r_phase;

  // Count system clocks within a half period and toggle the phase at its end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else if (!i_enable) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      r_count <= '0;
      r_phase <= !r_phase;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-stream SPI master, mode 0, MSB first, full duplex.
// Pulls bytes from a get/empty source, shifts them out while sampling miso,
// and pushes each received byte to a put/full sink. Chip select stays low
// across back-to-back bytes and rises one cycle after the stream drains.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in,
  output logic              get,
  input  logic              empty,
  output logic [BYTE_W-1:0] out,
  output logic              put,
  input  logic              full,
  output logic              spi_cs_n,
  output logic              spi_clock,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  state_t            r_state;
  logic [BYTE_W-1:0] r_tx;
  logic [BYTE_W-1:0] r_rx;
  logic [BYTE_W-1:0] r_out;
  logic [2:0]        r_bitCnt;
  logic              r_get;
  logic              r_put;
  logic              r_csN;
  logic              r_sclk;
  logic              w_shiftEn;
  logic              w_rise;
  logic              w_fall;

  assign w_shiftEn = (r_state == SHIFT);

  spi_clkdiv #(
    .DIV(DIV)
  ) u_clkdiv (
    .clock   (clock),
    .reset   (reset),
    .i_enable(w_shiftEn),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // The MSB of the tx shifter is the line itself, so mosi changes only when
  // the shifter is loaded or shifted and returns to 0 once a byte has drained.
  assign get       = r_get;
  assign put       = r_put;
  assign out       = r_out;
  assign spi_cs_n  = r_csN;
  assign spi_clock = r_sclk;
  assign spi_mosi  = r_tx[BYTE_W-1];

  // Transfer FSM: fetch a byte, shift it out, deliver the received byte.
  // put is raised on entry to DONE so it never overlaps the get of the next
  // FETCH; when the sink is full DONE waits with the SPI clock parked low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_tx     <= '0;
      r_rx     <= '0;
      r_out    <= '0;
      r_bitCnt <= '0;
      r_get    <= 1'b0;
      r_put    <= 1'b0;
      r_csN    <= 1'b1;
      r_sclk   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_csN <= 1'b1;
          if (!empty) begin
            r_state <= FETCH;
            r_get   <= 1'b1;
          end
        end

        FETCH: begin
          r_get   <= 1'b0;
          r_state <= LOAD;
        end

        LOAD: begin
          r_tx    <= in;
          r_csN   <= 1'b0;
          r_state <= SHIFT;
        end

        SHIFT: begin
          if (w_rise) begin
            r_sclk <= 1'b1;
            r_rx   <= {r_rx[BYTE_W-2:0], spi_miso};
          end else if (w_fall) begin
            r_sclk   <= 1'b0;
            r_tx     <= {r_tx[BYTE_W-2:0], 1'b0};
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              r_state <= DONE;
              if (!full) begin
                r_out <= r_rx;
                r_put <= 1'b1;
              end
            end
          end
        end

        DONE: begin
          if (r_put) begin
            r_put <= 1'b0;
            if (!empty) begin
              r_state <= FETCH;
              r_get   <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_csN   <= 1'b1;
            end
          end else if (!full) begin
            r_out <= r_rx;
            r_put <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master (DIV=1): loopback stream, single byte bit
// order, sink back-pressure, idle with an empty source, mid-byte reset and
// constant miso levels.
module tb_spi_master;

  localparam int DIV = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in;
  logic       get;
  logic       empty;
  logic [7:0] out;
  logic       put;
  logic       full;
  logic       spi_cs_n;
  logic       spi_clock;
  logic       spi_mosi;
  logic       spi_miso;

  logic [7:0] srcMem [16];
  int         srcLen;
  int         srcPtr;
  logic       misoLoop;
  logic       misoConst;
  logic       clearReq;

  int         checkCount = 0;
  int         errCount   = 0;

  int         cycleNum;
  int         getCycles, getDouble, overlap, putWhileFull;
  int         sclkRises, csLowCycles, csRises;
  logic [7:0] mosiByte;
  logic       prevGet, prevSclk, prevCs;
  logic [7:0] rxQ[$];
  int         getTimes[$];
  int         putTimes[$];

  spi_master #(
    .DIV(DIV)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in       (in),
    .get      (get),
    .empty    (empty),
    .out      (out),
    .put      (put),
    .full     (full),
    .spi_cs_n (spi_cs_n),
    .spi_clock(spi_clock),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clock = ~clock;

  assign in       = (srcPtr == 0) ? 8'h00 : srcMem[srcPtr-1];
  assign empty    = (srcPtr >= srcLen);
  assign spi_miso = misoLoop ? spi_mosi : misoConst;

  // Source model and monitor, sampled mid-cycle on the falling system clock.
  always @(negedge clock) begin
    cycleNum++;
    if (clearReq) begin
      srcPtr       = 0;
      getCycles    = 0;
      getDouble    = 0;
      overlap      = 0;
      putWhileFull = 0;
      sclkRises    = 0;
      csLowCycles  = 0;
      csRises      = 0;
      mosiByte     = 8'h00;
      rxQ.delete();
      getTimes.delete();
      putTimes.delete();
    end else begin
      if (get) begin
        srcPtr++;
        getCycles++;
        getTimes.push_back(cycleNum);
        if (prevGet) getDouble++;
      end
      if (get && put) overlap++;
      if (put) begin
        rxQ.push_back(out);
        putTimes.push_back(cycleNum);
        if (full) putWhileFull++;
      end
      if (spi_clock && !prevSclk) begin
        sclkRises++;
        mosiByte = {mosiByte[6:0], spi_mosi};
      end
      if (!spi_cs_n) csLowCycles++;
      if (spi_cs_n && !prevCs) csRises++;
    end
    prevGet  = get;
    prevSclk = spi_clock;
    prevCs   = spi_cs_n;
  end

  function automatic logic [31:0] rxAt(input int i);
    return (i < rxQ.size()) ? {24'h0, rxQ[i]} : 32'hDEAD;
  endfunction

  function automatic int putAt(input int i);
    return (i < putTimes.size()) ? putTimes[i] : -1000;
  endfunction

  function automatic int getAt(input int i);
    return (i < getTimes.size()) ? getTimes[i] : -1000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Clears the monitor and source pointer, then opens a source of len bytes.
  task automatic applyStimulus(input int len, input logic loop, input logic misoV);
    @(posedge clock); #1;
    clearReq  = 1'b1;
    srcLen    = 0;
    misoLoop  = loop;
    misoConst = misoV;
    @(posedge clock); #1;
    clearReq  = 1'b0;
    srcLen    = len;
  endtask

  task automatic waitPuts(input int n, input int budget);
    int c = 0;
    while (rxQ.size() < n && c < budget) begin
      @(posedge clock);
      c++;
    end
    if (rxQ.size() < n) checkOutput("put_timeout", rxQ.size(), n);
  endtask

  initial begin
    logic [7:0] hello [7];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
    cycleNum  = 0;
    reset     = 1'b1;
    full      = 1'b0;
    misoLoop  = 1'b1;
    misoConst = 1'b0;
    srcLen    = 0;
    clearReq  = 1'b1;
    for (int i = 0; i < 16; i++) srcMem[i] = 8'h00;

    // Reset values
    repeat (2) @(posedge clock); #1;
    checkOutput("rst_get", get, 1'b0);
    checkOutput("rst_put", put, 1'b0);
    checkOutput("rst_out", out, 8'h00);
    checkOutput("rst_cs_n", spi_cs_n, 1'b1);
    checkOutput("rst_sclk", spi_clock, 1'b0);
    checkOutput("rst_mosi", spi_mosi, 1'b0);
    reset = 1'b0;

    // Empty source: the bus stays quiet
    applyStimulus(0, 1'b1, 1'b0);
    repeat (40) @(posedge clock); #1;
    checkOutput("idle_gets", getCycles, 0);
    checkOutput("idle_puts", rxQ.size(), 0);
    checkOutput("idle_cs_low", csLowCycles, 0);
    checkOutput("idle_sclk", sclkRises, 0);

    // Single byte A5 in loopback
    srcMem[0] = 8'hA5;
    applyStimulus(1, 1'b1, 1'b0);
    waitPuts(1, 60);
    repeat (5) @(posedge clock); #1;
    checkOutput("a5_get_cycles", getCycles, 1);
    checkOutput("a5_sclk_pulses", sclkRises, 8);
    checkOutput("a5_mosi_bits", mosiByte, 8'hA5);
    checkOutput("a5_rx", rxAt(0), 8'hA5);
    checkOutput("a5_latency", putAt(0) - getAt(0), 18);
    checkOutput("a5_cs_n_end", spi_cs_n, 1'b1);

    // Seven back-to-back bytes in loopback
    for (int i = 0; i < 7; i++) srcMem[i] = hello[i];
    applyStimulus(7, 1'b1, 1'b0);
    waitPuts(7, 250);
    repeat (5) @(posedge clock); #1;
    for (int i = 0; i < 7; i++) checkOutput($sformatf("hello_rx%0d", i), rxAt(i), hello[i]);
    checkOutput("hello_puts", rxQ.size(), 7);
    checkOutput("hello_sclk", sclkRises, 56);
    checkOutput("hello_cs_rises", csRises, 1);
    checkOutput("hello_overlap", overlap, 0);
    checkOutput("hello_get_double", getDouble, 0);
    checkOutput("hello_spacing", putAt(6) - putAt(0), 114);

    // Sink full from mid byte 3 for 10 cycles
    applyStimulus(4, 1'b1, 1'b0);
    waitPuts(2, 100);
    repeat (12) @(posedge clock); #1;
    full = 1'b1;
    repeat (9) @(posedge clock); #1;
    checkOutput("stall_put", put, 1'b0);
    checkOutput("stall_sclk", spi_clock, 1'b0);
    checkOutput("stall_cs_n", spi_cs_n, 1'b0);
    checkOutput("stall_gets", getCycles, 3);
    @(posedge clock); #1;
    full = 1'b0;
    waitPuts(4, 100);
    repeat (5) @(posedge clock); #1;
    checkOutput("stall_rx2", rxAt(2), 8'h6C);
    checkOutput("stall_rx3", rxAt(3), 8'h6C);
    checkOutput("stall_puts", rxQ.size(), 4);
    checkOutput("stall_put_gap", putAt(2) - putAt(1), 24);
    checkOutput("stall_next_get", getAt(3) - putAt(2), 1);
    checkOutput("stall_put_full", putWhileFull, 0);
    checkOutput("stall_overlap", overlap, 0);

    // Reset during byte 2's shift
    applyStimulus(4, 1'b1, 1'b0);
    waitPuts(1, 60);
    repeat (7) @(posedge clock); #1;
    checkOutput("abort_pre_sclk", spi_clock, 1'b1);
    checkOutput("abort_pre_cs_n", spi_cs_n, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("abort_cs_n", spi_cs_n, 1'b1);
    checkOutput("abort_sclk", spi_clock, 1'b0);
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    waitPuts(3, 100);
    repeat (5) @(posedge clock); #1;
    checkOutput("abort_puts", rxQ.size(), 3);
    checkOutput("abort_rx0", rxAt(0), 8'h48);
    checkOutput("abort_rx1", rxAt(1), 8'h6C);
    checkOutput("abort_rx2", rxAt(2), 8'h6C);
    checkOutput("abort_gets", getCycles, 4);

    // Constant miso levels
    srcMem[0] = 8'h00;
    applyStimulus(1, 1'b0, 1'b1);
    waitPuts(1, 60);
    repeat (3) @(posedge clock); #1;
    checkOutput("miso_high", rxAt(0), 8'hFF);
    srcMem[0] = 8'hFF;
    applyStimulus(1, 1'b0, 1'b0);
    waitPuts(1, 60);
    repeat (3) @(posedge clock); #1;
    checkOutput("miso_low", rxAt(0), 8'h00);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  // Watchdog in case a wait somehow never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
